// File: rtl/vector_lsu_sequencer.sv
// Vector LSU sequencer: splits one vector load/store into beats of up to four element accesses.
// Build option VLSU_STRIDE_EN: when defined the stride input is honoured, otherwise accesses are unit-stride.
module vector_lsu_sequencer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  startValid,
  output logic                  startReady,
  input  logic                  isStore,
  input  logic [1:0]            sew,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [5:0]            vl,
  input  logic                  memStall,
  output logic [2:0]            writeEnable0,
  output logic [2:0]            writeEnable1,
  output logic [2:0]            writeEnable2,
  output logic [2:0]            writeEnable3,
  output logic [2:0]            readEnable0,
  output logic [2:0]            readEnable1,
  output logic [2:0]            readEnable2,
  output logic [2:0]            readEnable3,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic [ADDR_WIDTH-1:0] addr2,
  output logic [ADDR_WIDTH-1:0] addr3,
  output logic [31:0]           writeData0,
  output logic [31:0]           writeData1,
  output logic [31:0]           writeData2,
  output logic [31:0]           writeData3,
  input  logic [31:0]           readData0,
  input  logic [31:0]           readData1,
  input  logic [31:0]           readData2,
  input  logic [31:0]           readData3,
  output logic [5:0]            elemIdx,
  input  logic [31:0]           storeData0,
  input  logic [31:0]           storeData1,
  input  logic [31:0]           storeData2,
  input  logic [31:0]           storeData3,
  output logic                  wbValid,
  output logic [5:0]            wbIdx,
  output logic [3:0]            wbMask,
  output logic [31:0]           wbData0,
  output logic [31:0]           wbData1,
  output logic [31:0]           wbData2,
  output logic [31:0]           wbData3,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_nxt;

  logic                         is_store_p0;
  logic [1:0]                   sew_p0;
  logic [5:0]                   vl_p0;
  logic signed [ADDR_WIDTH-1:0] stride_p0;
  logic [ADDR_WIDTH-1:0]        ptr_p0;
  logic [5:0]                   elem_idx_p0;
  logic                         err_p0;

  logic                         vld_p1;
  logic [5:0]                   wb_idx_p1;
  logic [3:0]                   wb_mask_p1;
  logic [31:0]                  wb_data_p1 [4];

  logic [31:0]                  rd_data [4];
  logic [31:0]                  st_data [4];
  logic [3:0]                   lane_act;
  logic [3:0]                   lane_go;
  logic                         accept;
  logic                         beat_go;
  logic                         last_beat;
  logic [2:0]                   en_code;
  logic [ADDR_WIDTH-1:0]        lane_addr [4];
  logic [2:0]                   we_a [4];
  logic [2:0]                   re_a [4];
  logic [ADDR_WIDTH-1:0]        addr_a [4];
  logic [31:0]                  wdata_a [4];
  logic signed [ADDR_WIDTH-1:0] stride_sel;

  function automatic logic [2:0] sew_enables(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] sew_mask(input logic [31:0] d, input logic [1:0] s);
    case (s)
      2'b00:   return {24'd0, d[7:0]};
      2'b01:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] sew_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return ADDR_WIDTH'(1);
      2'b01:   return ADDR_WIDTH'(2);
      default: return ADDR_WIDTH'(4);
    endcase
  endfunction

`ifdef VLSU_STRIDE_EN
  assign stride_sel = stride;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign stride_sel    = sew_bytes(sew);
`endif

  assign rd_data = '{readData0, readData1, readData2, readData3};
  assign st_data = '{storeData0, storeData1, storeData2, storeData3};

  // Beat decode: reset gates the enables so an abort takes effect in the same cycle.
  always_comb begin
    accept    = (state == IDLE) && startValid;
    beat_go   = (state == ISSUE) && !memStall && !rst;
    last_beat = ({1'b0, elem_idx_p0} + 7'd4) >= {1'b0, vl_p0};
    en_code   = sew_enables(sew_p0);
    lane_addr[0] = ptr_p0;
    lane_addr[1] = ptr_p0 + stride_p0;
    lane_addr[2] = ptr_p0 + (stride_p0 <<< 1);
    lane_addr[3] = lane_addr[2] + stride_p0;
    for (int k = 0; k < 4; k++) begin
      lane_act[k] = (state == ISSUE) && (({1'b0, elem_idx_p0} + 7'(k)) < {1'b0, vl_p0});
      lane_go[k]  = beat_go && lane_act[k];
      we_a[k]     = (lane_go[k] && is_store_p0)  ? en_code : 3'b000;
      re_a[k]     = (lane_go[k] && !is_store_p0) ? en_code : 3'b000;
      addr_a[k]   = lane_go[k] ? lane_addr[k] : '0;
      wdata_a[k]  = (lane_go[k] && is_store_p0) ? st_data[k] : 32'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (startValid && (sew != 2'b11)) begin
          state_nxt = (vl == 6'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (beat_go && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // p0: request fields and beat pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_p0 <= 1'b0;
      sew_p0      <= 2'b00;
      vl_p0       <= 6'd0;
      stride_p0   <= '0;
      ptr_p0      <= '0;
      elem_idx_p0 <= 6'd0;
      err_p0      <= 1'b0;
    end else begin
      err_p0 <= accept && (sew == 2'b11);
      if (accept) begin
        is_store_p0 <= isStore;
        sew_p0      <= sew;
        vl_p0       <= (vl > 6'd32) ? 6'd32 : vl;
        stride_p0   <= stride_sel;
        ptr_p0      <= baseAddr;
        elem_idx_p0 <= 6'd0;
      end else if (beat_go) begin
        elem_idx_p0 <= elem_idx_p0 + 6'd4;
        ptr_p0      <= ptr_p0 + (stride_p0 <<< 2);
      end
    end
  end

  // p1: registered load writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      wb_idx_p1  <= 6'd0;
      wb_mask_p1 <= 4'b0000;
      for (int k = 0; k < 4; k++) wb_data_p1[k] <= 32'd0;
    end else begin
      vld_p1     <= beat_go && !is_store_p0;
      wb_mask_p1 <= (beat_go && !is_store_p0) ? lane_act : 4'b0000;
      if (beat_go && !is_store_p0) begin
        wb_idx_p1 <= elem_idx_p0;
        for (int k = 0; k < 4; k++) begin
          wb_data_p1[k] <= lane_act[k] ? sew_mask(rd_data[k], sew_p0) : 32'd0;
        end
      end
    end
  end

  assign startReady   = (state == IDLE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign error        = err_p0;
  assign elemIdx      = elem_idx_p0;
  assign wbValid      = vld_p1;
  assign wbIdx        = wb_idx_p1;
  assign wbMask       = wb_mask_p1;
  assign wbData0      = wb_data_p1[0];
  assign wbData1      = wb_data_p1[1];
  assign wbData2      = wb_data_p1[2];
  assign wbData3      = wb_data_p1[3];
  assign writeEnable0 = we_a[0];
  assign writeEnable1 = we_a[1];
  assign writeEnable2 = we_a[2];
  assign writeEnable3 = we_a[3];
  assign readEnable0  = re_a[0];
  assign readEnable1  = re_a[1];
  assign readEnable2  = re_a[2];
  assign readEnable3  = re_a[3];
  assign addr0        = addr_a[0];
  assign addr1        = addr_a[1];
  assign addr2        = addr_a[2];
  assign addr3        = addr_a[3];
  assign writeData0   = wdata_a[0];
  assign writeData1   = wdata_a[1];
  assign writeData2   = wdata_a[2];
  assign writeData3   = wdata_a[3];

endmodule

// File: tb/tb_vector_lsu_sequencer.sv
// Bench for vector_lsu_sequencer: byte-addressed memory model, element-level reference model, randomized ops.
module tb_vector_lsu_sequencer;
  localparam int AW    = 10;
  localparam int MEMSZ = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, startValid, startReady, isStore, memStall;
  logic [1:0]    sew;
  logic [AW-1:0] baseAddr, stride;
  logic [5:0]    vl, elemIdx, wbIdx;
  logic [2:0]    writeEnable0, writeEnable1, writeEnable2, writeEnable3;
  logic [2:0]    readEnable0, readEnable1, readEnable2, readEnable3;
  logic [AW-1:0] addr0, addr1, addr2, addr3;
  logic [31:0]   writeData0, writeData1, writeData2, writeData3;
  logic [31:0]   readData0, readData1, readData2, readData3;
  logic [31:0]   storeData0, storeData1, storeData2, storeData3;
  logic [31:0]   wbData0, wbData1, wbData2, wbData3;
  logic          wbValid, busy, done, error;
  logic [3:0]    wbMask;

  vector_lsu_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .startValid(startValid), .startReady(startReady),
    .isStore(isStore), .sew(sew), .baseAddr(baseAddr), .stride(stride), .vl(vl),
    .memStall(memStall),
    .writeEnable0(writeEnable0), .writeEnable1(writeEnable1),
    .writeEnable2(writeEnable2), .writeEnable3(writeEnable3),
    .readEnable0(readEnable0), .readEnable1(readEnable1),
    .readEnable2(readEnable2), .readEnable3(readEnable3),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .writeData0(writeData0), .writeData1(writeData1),
    .writeData2(writeData2), .writeData3(writeData3),
    .readData0(readData0), .readData1(readData1),
    .readData2(readData2), .readData3(readData3),
    .elemIdx(elemIdx),
    .storeData0(storeData0), .storeData1(storeData1),
    .storeData2(storeData2), .storeData3(storeData3),
    .wbValid(wbValid), .wbIdx(wbIdx), .wbMask(wbMask),
    .wbData0(wbData0), .wbData1(wbData1), .wbData2(wbData2), .wbData3(wbData3),
    .busy(busy), .done(done), .error(error)
  );

  logic [2:0]    we [4];
  logic [2:0]    re [4];
  logic [AW-1:0] ad [4];
  logic [31:0]   wd [4];
  logic [31:0]   wbd [4];
  logic [31:0]   rdw [4];
  logic [31:0]   sdw [4];
  logic [23:0]   all_en;

  assign we  = '{writeEnable0, writeEnable1, writeEnable2, writeEnable3};
  assign re  = '{readEnable0, readEnable1, readEnable2, readEnable3};
  assign ad  = '{addr0, addr1, addr2, addr3};
  assign wd  = '{writeData0, writeData1, writeData2, writeData3};
  assign wbd = '{wbData0, wbData1, wbData2, wbData3};
  assign all_en = {writeEnable0, writeEnable1, writeEnable2, writeEnable3,
                   readEnable0, readEnable1, readEnable2, readEnable3};
  assign readData0  = rdw[0];
  assign readData1  = rdw[1];
  assign readData2  = rdw[2];
  assign readData3  = rdw[3];
  assign storeData0 = sdw[0];
  assign storeData1 = sdw[1];
  assign storeData2 = sdw[2];
  assign storeData3 = sdw[3];

  logic [7:0]  mem [MEMSZ];
  logic [7:0]  exp_mem [MEMSZ];
  logic [31:0] sdata [36];
  logic        fill, pl_en;
  int          pl_addr;
  logic [7:0]  pl_data;

  int errors = 0;
  int checks = 0;

  // Memory: combinational little-endian reads, byte writes in port order so lane 3 wins.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rdw[k] = {mem[(int'(ad[k]) + 3) % MEMSZ], mem[(int'(ad[k]) + 2) % MEMSZ],
                mem[(int'(ad[k]) + 1) % MEMSZ], mem[int'(ad[k]) % MEMSZ]};
      sdw[k] = ((int'(elemIdx) + k) < 36) ? sdata[(int'(elemIdx) + k) % 36] : 32'd0;
    end
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < MEMSZ; i++) mem[i] <= 8'($urandom);
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (we[k][0]) mem[int'(ad[k])]               <= wd[k][7:0];
        if (we[k][1]) mem[(int'(ad[k]) + 1) % MEMSZ] <= wd[k][15:8];
        if (we[k][2]) begin
          mem[(int'(ad[k]) + 2) % MEMSZ] <= wd[k][23:16];
          mem[(int'(ad[k]) + 3) % MEMSZ] <= wd[k][31:24];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int elem_bytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int elem_addr(input logic [AW-1:0] base, input int s, input int e);
    int r;
    r = (int'(base) + e * s) % MEMSZ;
    if (r < 0) r += MEMSZ;
    return r;
  endfunction

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    exp_mem[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Drives one request and checks every cycle until done against the element-level model.
  task automatic run_vector_op(input string tag, input logic st, input logic [1:0] sw,
                               input logic [AW-1:0] base, input logic [AW-1:0] strd,
                               input logic [5:0] vlen, input logic [31:0] stalls);
    int n, eb, s, nbeats, beat, cyc, e, a, pend_beat, bad;
    logic pend;
    logic [2:0] code, xwe, xre;
    logic [3:0] mask;
    logic [31:0] val;
    n      = (int'(vlen) > 32) ? 32 : int'(vlen);
    eb     = elem_bytes(sw);
    code   = (eb == 1) ? 3'b001 : (eb == 2) ? 3'b011 : 3'b111;
`ifdef VLSU_STRIDE_EN
    s = int'($signed(strd));
`else
    s = eb;
`endif
    nbeats = (n + 3) / 4;
    if (st) begin
      for (int i = 0; i < n; i++) begin
        a = elem_addr(base, s, i);
        for (int b = 0; b < eb; b++) exp_mem[(a + b) % MEMSZ] = sdata[i][8*b +: 8];
      end
    end
    @(negedge clk); #1;
    checks++;
    if (startReady !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s ready: got ready=%0b done=%0b want ready=1 done=0", tag, startReady, done);
    end
    startValid = 1'b1; isStore = st; sew = sw; baseAddr = base; stride = strd; vl = vlen;
    @(negedge clk);
    startValid = 1'b0;
    beat = 0; cyc = 0; pend = 1'b0; pend_beat = 0;
    forever begin
      memStall = (beat < nbeats && cyc < 32) ? stalls[cyc] : 1'b0;
      #1;
      if (pend) begin
        mask = '0;
        for (int k = 0; k < 4; k++) if (4 * pend_beat + k < n) mask[k] = 1'b1;
        checks++;
        if (wbValid !== 1'b1 || wbIdx !== 6'(4 * pend_beat) || wbMask !== mask) begin
          errors++;
          $display("FAIL %s wb beat%0d: got v=%0b idx=%0d mask=%b want v=1 idx=%0d mask=%b",
                   tag, pend_beat, wbValid, wbIdx, wbMask, 4 * pend_beat, mask);
        end
        for (int k = 0; k < 4; k++) begin
          if (mask[k]) begin
            a = elem_addr(base, s, 4 * pend_beat + k);
            val = '0;
            for (int b = 0; b < eb; b++) val[8*b +: 8] = exp_mem[(a + b) % MEMSZ];
            checks++;
            if (wbd[k] !== val) begin
              errors++;
              $display("FAIL %s wbData beat%0d lane%0d: got %h want %h", tag, pend_beat, k, wbd[k], val);
            end
          end
        end
      end else begin
        checks++;
        if (wbValid !== 1'b0) begin
          errors++;
          $display("FAIL %s wbValid idle cyc%0d: got %0b want 0", tag, cyc, wbValid);
        end
      end
      pend = 1'b0;
      if (beat == nbeats) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || all_en !== 24'd0) begin
          errors++;
          $display("FAIL %s done: got done=%0b busy=%0b en=%h want done=1 busy=1 en=0",
                   tag, done, busy, all_en);
        end
        break;
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || elemIdx !== 6'(4 * beat)) begin
        errors++;
        $display("FAIL %s issue cyc%0d: got done=%0b busy=%0b elemIdx=%0d want done=0 busy=1 elemIdx=%0d",
                 tag, cyc, done, busy, elemIdx, 4 * beat);
      end
      if (memStall) begin
        checks++;
        if (all_en !== 24'd0) begin
          errors++;
          $display("FAIL %s stall cyc%0d: got en=%h want 0", tag, cyc, all_en);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          e = 4 * beat + k;
          xwe = (e < n && st)  ? code : 3'b000;
          xre = (e < n && !st) ? code : 3'b000;
          a = (e < n) ? elem_addr(base, s, e) : 0;
          checks++;
          if (we[k] !== xwe || re[k] !== xre ||
              (e < n && ad[k] !== AW'(a)) || (e < n && st && wd[k] !== sdata[e])) begin
            errors++;
            $display("FAIL %s lane%0d elem%0d: got we=%b re=%b addr=%h wd=%h want we=%b re=%b addr=%h wd=%h",
                     tag, k, e, we[k], re[k], ad[k], wd[k], xwe, xre, AW'(a), st ? sdata[e % 36] : 32'd0);
          end
        end
        if (!st) begin
          pend = 1'b1;
          pend_beat = beat;
        end
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    bad = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== exp_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s memory: got %0d differing bytes want 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fill = 1'b1; pl_en = 1'b0; pl_addr = 0; pl_data = '0;
    startValid = 1'b0; isStore = 1'b0; sew = 2'b00; baseAddr = '0; stride = '0;
    vl = '0; memStall = 1'b0;
    for (int i = 0; i < 36; i++) sdata[i] = 32'(i);
    @(posedge clk); #1 fill = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    for (int i = 0; i < MEMSZ; i++) exp_mem[i] = mem[i];
    checks++;
    if (startReady !== 1'b1 || {busy, done, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset ctrl: got ready=%0b busy=%0b done=%0b err=%0b want 1 0 0 0",
               startReady, busy, done, error);
    end
    checks++;
    if (all_en !== 24'd0 || {addr0, addr1, addr2, addr3} !== '0) begin
      errors++;
      $display("FAIL reset mem-side: got en=%h addr0=%h want 0", all_en, addr0);
    end
    checks++;
    if ({writeData0, writeData1, writeData2, writeData3} !== '0 ||
        {wbData0, wbData1, wbData2, wbData3} !== '0) begin
      errors++;
      $display("FAIL reset data: got wd0=%h wb0=%h want 0", writeData0, wbData0);
    end
    checks++;
    if (elemIdx !== 6'd0 || wbValid !== 1'b0 || wbMask !== 4'd0 || wbIdx !== 6'd0) begin
      errors++;
      $display("FAIL reset wb: got idx=%0d v=%0b mask=%b wbIdx=%0d want 0", elemIdx, wbValid, wbMask, wbIdx);
    end
  endtask

  task automatic test_unit_store();
    logic [31:0] w;
    for (int i = 0; i < 36; i++) sdata[i] = 32'(i);
    run_vector_op("unit_st32", 1'b1, 2'b10, 10'h000, 10'd4, 6'd8, 32'd0);
    for (int k = 0; k < 8; k++) begin
      w = {mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]};
      checks++;
      if (w !== 32'(k)) begin
        errors++;
        $display("FAIL unit_st32 word%0d: got %h want %h", k, w, k);
      end
    end
  endtask

  task automatic test_byte_load();
    for (int i = 0; i < 6; i++) preload(16 + i, 8'(8'h80 + i));
    run_vector_op("ld8", 1'b0, 2'b00, 10'h010, 10'd1, 6'd6, 32'd0);
  endtask

  task automatic test_strided_load();
    run_vector_op("ld16_neg", 1'b0, 2'b01, 10'h100, 10'h3FC, 6'd3, 32'd0);
  endtask

  task automatic test_stall();
    run_vector_op("ld_stall", 1'b0, 2'b10, 10'h040, 10'd4, 6'd12, 32'h0000_0006);
  endtask

  task automatic test_vl_zero();
    run_vector_op("vl0", 1'b1, 2'b10, 10'h080, 10'd4, 6'd0, 32'd0);
  endtask

  task automatic test_illegal_sew();
    @(negedge clk); #1;
    startValid = 1'b1; isStore = 1'b1; sew = 2'b11; baseAddr = 10'h020; stride = 10'd4; vl = 6'd5;
    @(negedge clk);
    startValid = 1'b0; #1;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || startReady !== 1'b1 || all_en !== 24'd0) begin
      errors++;
      $display("FAIL sew11 pulse: got err=%0b busy=%0b ready=%0b en=%h want 1 0 1 0",
               error, busy, startReady, all_en);
    end
    @(negedge clk); #1;
    checks++;
    if (error !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL sew11 after: got err=%0b busy=%0b done=%0b want 0 0 0", error, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 36; i++) sdata[i] = $urandom;
    run_vector_op("b2b_st", 1'b1, 2'b01, 10'h300, 10'd2, 6'd7, 32'd0);
    run_vector_op("b2b_ld", 1'b0, 2'b01, 10'h300, 10'd2, 6'd7, 32'd0);
  endtask

  task automatic test_overlap_and_clamp();
    for (int i = 0; i < 36; i++) sdata[i] = $urandom;
    run_vector_op("ovl_st", 1'b1, 2'b10, 10'h0C0, 10'd0, 6'd6, 32'd0);
    run_vector_op("clamp_ld", 1'b0, 2'b00, 10'h3F0, 10'd1, 6'd40, 32'd0);
  endtask

  task automatic test_random();
    logic [5:0] rvl;
    for (int op = 0; op < 10; op++) begin
      for (int i = 0; i < 36; i++) sdata[i] = $urandom;
      rvl = 6'($urandom_range(0, 40));
      run_vector_op($sformatf("rnd%0d", op), 1'($urandom), 2'($urandom_range(0, 2)),
                    AW'($urandom), AW'($urandom_range(0, 63) - 32), rvl,
                    $urandom & $urandom & $urandom);
    end
  endtask

  task automatic test_reset_abort();
    int a;
    for (int i = 0; i < 36; i++) sdata[i] = $urandom;
    for (int e = 0; e < 4; e++) begin
      a = elem_addr(10'h200, 4, e);
      for (int b = 0; b < 4; b++) exp_mem[(a + b) % MEMSZ] = sdata[e][8*b +: 8];
    end
    @(negedge clk); #1;
    startValid = 1'b1; isStore = 1'b1; sew = 2'b10; baseAddr = 10'h200; stride = 10'd4; vl = 6'd16;
    @(negedge clk);
    startValid = 1'b0; #1;
    checks++;
    if (writeEnable0 !== 3'b111 || addr3 !== 10'h20C) begin
      errors++;
      $display("FAIL abort beat1: got we0=%b addr3=%h want 111 20c", writeEnable0, addr3);
    end
    @(negedge clk);
    rst = 1'b1; #1;
    checks++;
    if (all_en !== 24'd0) begin
      errors++;
      $display("FAIL abort beat2 enables: got %h want 0", all_en);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if (startReady !== 1'b1 || {busy, done, error, wbValid} !== 4'b0000 || elemIdx !== 6'd0 ||
        all_en !== 24'd0 || {addr0, addr1, addr2, addr3} !== '0 || writeData0 !== 32'd0) begin
      errors++;
      $display("FAIL abort outputs: got ready=%0b busy=%0b done=%0b idx=%0d en=%h want reset values",
               startReady, busy, done, elemIdx, all_en);
    end
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < MEMSZ; i++) if (mem[i] !== exp_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL abort memory: got %0d differing bytes want 0", bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit_store();
    test_byte_load();
    test_strided_load();
    test_stall();
    test_vl_zero();
    test_illegal_sew();
    test_back_to_back();
    test_overlap_and_clamp();
    test_random();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_lsu_sequencer.md
# vector_lsu_sequencer

Sequencer between the vector execute stage and the 4-port data memory. Accepts one vector load or store (base, stride, element width, vl) and breaks it into beats of up to four element accesses per cycle, one element per memory port. Generates per-port addresses and 3-bit byte-lane enables, and forwards store data. Returns registered load data as element-indexed writebacks to the vector register file.

## Interface
- ADDR_WIDTH, 10, byte-address width of the data memory
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- startValid  in  1  request valid
- startReady  out  1  high only in IDLE
- isStore  in  1  1 = store, 0 = load
- sew  in  2  element width: 00 = 8b, 01 = 16b, 10 = 32b, 11 = illegal
- baseAddr  in  ADDR_WIDTH  byte address of element 0
- stride  in  ADDR_WIDTH  byte stride, two's complement
- vl  in  6  element count, 0..32; values >32 are clamped to 32
- memStall  in  1  suppresses beat issue this cycle
- writeEnable0..3  out  3 each  byte-lane write enables per port
- readEnable0..3  out  3 each  byte-lane read enables per port
- addr0..3  out  ADDR_WIDTH each  per-port byte address
- writeData0..3  out  32 each  store data per port
- readData0..3  in  32 each  combinational memory read data
- elemIdx  out  6  index of the first element in the current beat
- storeData0..3  in  32 each  VRF data for elements elemIdx+0..3, combinational
- wbValid  out  1  load writeback valid
- wbIdx  out  6  first element index of the writeback
- wbMask  out  4  per-lane writeback valid
- wbData0..3  out  32 each  zero-extended load elements
- busy  out  1  high in ISSUE and DONE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse on illegal sew

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE, on startValid: latch all request fields; elemIdx = 0; lane pointer = baseAddr.
  - If sew = 11: pulse error next cycle; remain in IDLE; no memory access.
  - Else if vl = 0: go to DONE.
  - Else: go to ISSUE.
- Enable code per sew: 8b = 3'b001, 16b = 3'b011, 32b = 3'b111.
- ISSUE, with memStall low:
  - Lane k is active when elemIdx+k < vl.
  - addr_k = pointer + k*stride, modulo 2^ADDR_WIDTH.
  - Stores drive the write enables with the sew code and writeData_k = storeData_k. Loads drive the read enables with the sew code.
  - Inactive lanes drive all enables at 0.
  - After the beat: elemIdx += 4; pointer += 4*stride. If that beat covered element vl-1, go to DONE.
- ISSUE, with memStall high: all enables 0; elemIdx and pointer hold.
- Load capture: readData_k is masked to sew (upper bits zeroed) and registered. The following cycle drives wbValid = 1, wbIdx = the beat's elemIdx, and wbMask = active lanes. Stores never assert wbValid.
- DONE: done = 1 for one cycle, then return to IDLE.
- Same-beat address overlap on stores: memory port order applies, so the higher-numbered lane wins. Alignment is not checked.
- rst mid-operation: aborts immediately. No further enables; any pending writeback is dropped.

## Timing
- Reset values: state IDLE, startReady 1, all enables 0, addr*/writeData*/wbData* 0, elemIdx 0, wbValid/wbMask/wbIdx 0, busy/done/error 0.
- Request accepted at edge N:
  - First beat is in cycle N+1.
  - With no stalls, the last beat is in cycle N+ceil(vl/4).
  - done is high in cycle N+ceil(vl/4)+1.
- Each stall cycle adds one cycle.
- The final load wbValid coincides with done.
- vl = 0: done in cycle N+1, with no enables ever asserted.
- Illegal sew: error high in cycle N+1; startReady stays 1.
- The next request can be accepted in the cycle after done.

## Configuration
- VLSU_STRIDE_EN defined: the stride input is honoured as specified.
- VLSU_STRIDE_EN undefined: the stride input is ignored. Effective stride = element bytes (1/2/4), i.e. unit-stride only.

## Test plan
- Unit-stride 32b store: vl = 8, base 0x000, storeData = element index. Expect 2 beats at addresses 0,4,8,12 then 16,20,24,28; enables 3'b111; done in cycle N+3; memory word k = k.
- 8b load, vl = 6, base 0x010, memory bytes 0x80..0x85:
  - Beat 1: addresses 0x10..0x13, mask 4'b1111, wbData = 0x00000080..0x83.
  - Beat 2: mask 4'b0011, wbIdx = 4.
- 16b strided load, stride = -4, base 0x100, vl = 3: addresses 0x100, 0x0FC, 0x0F8; lane 3 enables 0; read enables 3'b011.
- memStall high for 2 cycles during beat 2 of a vl = 12 load: enables 0 and elemIdx = 4 held; done delayed by exactly 2 cycles.
- vl = 0 gives done at N+1 with no enables. sew = 11 gives an error pulse and no busy.
- rst asserted during beat 2 of a vl = 16 store: all outputs at reset values the next cycle; only beat 1 was written to memory.
